rx_iq_packer: RTL

Consumes the 32-bit I/Q word stream that the receiver data path writes into the RX sample FIFO (I word then Q word, 24-bit sample in bits [23:0]). Packs pairs of 24-bit I/Q samples into dense 32-bit words and frames them as fixed-length Avalon-ST packets for the DMA/CPU side. Runs entirely in the `clk` (system) domain on the FIFO read side.

---
 rtl/rx_iq_packer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/rx_iq_packer.sv
// Packs 24-bit I/Q FIFO words, 4 words to 3 dense words, into fixed-length Avalon-ST packets.
// Optional macro RX_PACKER_SEQ_EN adds a {16'hA55A, seq} header word at the start of each packet.
module rx_iq_packer #(
    parameter int SAMPLES_PER_PKT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] fifo_readdata,
    input  logic        fifo_empty,
    output logic        fifo_read,
    output logic [31:0] src_data,
    output logic        src_valid,
    input  logic        src_ready,
    output logic        src_sop,
    output logic        src_eop,
    output logic [15:0] pkt_count
);

    localparam int GROUPS = SAMPLES_PER_PKT / 2;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [GW-1:0] LAST_GRP = GW'(GROUPS - 1);

`ifdef RX_PACKER_SEQ_EN
    localparam bit HAS_HDR = 1'b1;
    typedef enum logic [2:0] {S_IDLE, S_GATHER, S_EMIT0, S_EMIT1, S_EMIT2, S_HDR} state_t;
`else
    localparam bit HAS_HDR = 1'b0;
    typedef enum logic [2:0] {S_IDLE, S_GATHER, S_EMIT0, S_EMIT1, S_EMIT2} state_t;
`endif

    state_t          r_state;
    logic [1:0]      r_idx;
    logic [GW-1:0]   r_grp;
    logic [23:0]     r_ia;
    logic [23:0]     r_qa;
    logic [23:0]     r_ib;
    logic [23:0]     r_qb;
`ifdef RX_PACKER_SEQ_EN
    logic [15:0]     r_seq;
`endif

    logic            w_accept;
    logic            w_last_grp;
    logic [23:0]     w_sample;
    logic [31:0]     w_w0;
    logic [31:0]     w_w1;
    logic [31:0]     w_w2;
    logic            w_unused_hi;

    // The upper byte of each FIFO word carries nothing for this block.
    assign w_unused_hi = ^fifo_readdata[31:24];
    assign w_sample    = fifo_readdata[23:0];

    assign w_accept   = src_valid & src_ready;
    assign w_last_grp = (r_grp == LAST_GRP);
    // w0 is formed from IA and QA, which are already held when QB is captured.
    assign w_w0 = {r_ia, r_qa[23:16]};
    assign w_w1 = {r_qa[15:0], r_ib[23:8]};
    assign w_w2 = {r_ib[7:0], r_qb};

    assign fifo_read = (r_state == S_GATHER) & ~fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= 2'd0;
            r_grp     <= '0;
            r_ia      <= 24'd0;
            r_qa      <= 24'd0;
            r_ib      <= 24'd0;
            r_qb      <= 24'd0;
            src_data  <= 32'd0;
            src_valid <= 1'b0;
            src_sop   <= 1'b0;
            src_eop   <= 1'b0;
            pkt_count <= 16'd0;
`ifdef RX_PACKER_SEQ_EN
            r_seq     <= 16'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
`ifdef RX_PACKER_SEQ_EN
                        src_data  <= {16'hA55A, r_seq};
                        src_valid <= 1'b1;
                        src_sop   <= 1'b1;
                        r_state   <= S_HDR;
`else
                        r_state   <= S_GATHER;
`endif
                    end
                end
`ifdef RX_PACKER_SEQ_EN
                S_HDR: begin
                    if (w_accept) begin
                        src_valid <= 1'b0;
                        src_sop   <= 1'b0;
                        r_state   <= S_GATHER;
                    end
                end
`endif
                S_GATHER: begin
                    if (!fifo_empty) begin
                        case (r_idx)
                            2'd0:    r_ia <= w_sample;
                            2'd1:    r_qa <= w_sample;
                            2'd2:    r_ib <= w_sample;
                            default: r_qb <= w_sample;
                        endcase
                        r_idx <= 2'(r_idx + 2'd1);
                        if (r_idx == 2'd3) begin
                            src_data  <= w_w0;
                            src_valid <= 1'b1;
                            src_sop   <= ~HAS_HDR & (r_grp == '0);
                            r_state   <= S_EMIT0;
                        end
                    end
                end
                S_EMIT0: begin
                    if (w_accept) begin
                        src_data <= w_w1;
                        src_sop  <= 1'b0;
                        r_state  <= S_EMIT1;
                    end
                end
                S_EMIT1: begin
                    if (w_accept) begin
                        src_data <= w_w2;
                        src_eop  <= w_last_grp;
                        r_state  <= S_EMIT2;
                    end
                end
                S_EMIT2: begin
                    if (w_accept) begin
                        src_valid <= 1'b0;
                        src_eop   <= 1'b0;
                        if (w_last_grp) begin
                            r_grp     <= '0;
                            pkt_count <= 16'(pkt_count + 16'd1);
`ifdef RX_PACKER_SEQ_EN
                            r_seq     <= 16'(r_seq + 16'd1);
`endif
                            r_state   <= S_IDLE;
                        end else begin
                            r_grp   <= GW'(r_grp + 1'b1);
                            r_state <= S_GATHER;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
